// File: rtl/fsm_1.sv
// Moore detector for the serial pattern 1-1-0-1 with overlap; out pulses for
// one cycle in the detect state S4.
module fsm_1 (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   out_q;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = in ? S1 : S0;
            S1:      state_d = in ? S2 : S0;
            S2:      state_d = in ? S2 : S3;
            S3:      state_d = in ? S4 : S0;
            // Trailing "11" of a detect is reused as the next prefix.
            S4:      state_d = in ? S2 : S0;
            default: state_d = S0;
        endcase
    end

    // out_q mirrors (state_q == S4), registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == S4);
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_fsm_1.sv
// Bench for fsm_1: directed vector table, hand-written corner sequences and
// random stream checked against a suffix-matching reference model.
module tb_fsm_1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in = 1'b0;
    logic out;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_1 dut (.clk(clk), .reset(reset), .in(in), .out(out));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       bit_in;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];
    bit   hist[$];
    bit [3:0] pat = 4'b1101;

    // Longest suffix of the history that is a prefix of 1101 (4 = full match).
    function automatic int match_len(input bit h[$], input bit [3:0] p);
        for (int k = 4; k >= 1; k--) begin
            if (h.size() >= k) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (h[h.size() - k + j] != p[3 - j]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic b);
        @(negedge clk);
        reset = r;
        in    = b;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic check_model(input string name);
        int ml;
        ml = match_len(hist, pat);
        check({name, "_out"}, int'(out), (ml == 4) ? 1 : 0);
        check({name, "_state"}, int'(dut.state_q), ml);
    endtask

    function automatic void add(input logic r, input logic b, input int st);
        vec_t v;
        v.rst = r; v.bit_in = b; v.st = st[2:0];
        tbl.push_back(v);
    endfunction

    initial begin
        // Reset with in=1, then idle zeros.
        add(1,1,0); add(0,0,0); add(0,0,0); add(0,0,0);
        // Basic detect 1,1,0,1,0.
        add(0,1,1); add(0,1,2); add(0,0,3); add(0,1,4); add(0,0,0);
        // Overlap 1,1,0,1,1,0,1,0.
        add(0,1,1); add(0,1,2); add(0,0,3); add(0,1,4);
        add(0,1,2); add(0,0,3); add(0,1,4); add(0,0,0);
        // Long run of ones 1,1,1,1,0,1.
        add(0,1,1); add(0,1,2); add(0,1,2); add(0,1,2); add(0,0,3); add(0,1,4);
        // Reset out of S4, then near misses.
        add(1,0,0);
        add(0,1,1); add(0,0,0); add(0,1,1); add(0,0,0); add(0,1,1); add(0,1,2);
        add(0,1,2); add(0,0,3); add(0,0,0); add(0,1,1); add(0,0,0); add(0,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].bit_in);
            check($sformatf("vec%0d_out", i), int'(out), (tbl[i].st == 3'd4) ? 1 : 0);
            check($sformatf("vec%0d_state", i), int'(dut.state_q), int'(tbl[i].st));
        end

        // Reset mid-match discards partial progress.
        drive(1, 0);
        drive(0, 1); drive(0, 1); drive(0, 0);
        check("mid_pre_state", int'(dut.state_q), 3);
        drive(1, 1);
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_state", int'(dut.state_q), 0);
        drive(0, 1); drive(0, 1); drive(0, 0);
        check("mid_3_out", int'(out), 0);
        drive(0, 1);
        check("mid_4_out", int'(out), 1);
        drive(0, 0);
        check("mid_5_out", int'(out), 0);

        // A reset pulse that spans no rising edge has no effect.
        drive(0, 1); drive(0, 1);
        @(negedge clk);
        in = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        hist.push_back(1'b0);
        check("glitch_state", int'(dut.state_q), 3);
        drive(0, 1);
        check("glitch_out", int'(out), 1);

        // Randomized stream against the suffix model.
        drive(1, 0);
        check_model("rnd_rst");
        for (int i = 0; i < 2000; i++) begin
            logic r, b;
            r = ($urandom_range(0, 63) == 0);
            b = ($urandom_range(0, 99) < 65);
            drive(r, b);
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_1.md
# fsm_1

Single-input Moore sequence detector. It samples a serial bit stream `in` on every rising clock edge. It raises `out` for one cycle each time the stream has just ended with the pattern 1-1-0-1, with overlapping occurrences allowed. It is a leaf block: it takes one bit per cycle from upstream logic and drives a one-cycle detect flag to downstream control.

## Interface
- Parameters: none (pattern 1101 and state encoding are fixed).
- `clk` input 1 — sole clock; all state changes on its rising edge.
- `reset` input 1 — synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `in` input 1 — serial data bit, sampled at each rising edge of `clk`.
- `out` output 1 — detect flag; high for exactly the cycle(s) the FSM is in state S4.

## Operation
- States, 3-bit binary encoding, held in a single state register:
  - S0 = 0: no prefix matched
  - S1 = 1: matched "1"
  - S2 = 2: matched "11"
  - S3 = 3: matched "110"
  - S4 = 4: matched "1101", the detect state
- Transitions on each rising edge when `reset`=0:
  - From S0: in=1 → S1; in=0 → S0.
  - From S1: in=1 → S2; in=0 → S0.
  - From S2: in=1 → S2; in=0 → S3.
  - From S3: in=1 → S4; in=0 → S0.
  - From S4: in=1 → S2 (the trailing "11" is reused); in=0 → S0.
- Illegal codes 5–7: next state S0 regardless of `in`. `out`=0 while in an illegal code.
- Output logic:
  - Moore: `out` = (state == S4), decoded from the state register only.
  - `out` has no combinational path from `in`.
- Reset:
  - If `reset`=1 at a rising edge, the state becomes S0 and `in` is ignored.
  - Reset has priority over every transition.
- Power-up state before the first reset edge is undefined. Consumers must apply reset across at least one rising edge.

## Timing
- Reset value: state S0, `out`=0, valid from the first rising edge with `reset`=1.
- Latency: the edge that samples the final '1' of 1101 moves the FSM to S4. `out` goes high right after that edge and stays high for one clock period.
- `out` deasserts at the next edge unless a new match completes. A new match cannot complete immediately, because S4 with in=1 goes to S2, not S4. So `out` never stays high for more than one consecutive cycle.
- Overlap: after a detect, a stream continuing "101" produces the next detect 3 edges later.
- Reset mid-sequence: all partial progress is discarded. A full 1101 must be sampled after reset deasserts.
- A reset pulse that does not span a rising edge has no effect.
- `in` must meet setup/hold around the rising edge. Benches change `in` at the falling edge.

## Test plan
- Reset: hold `reset`=1 over one rising edge with in=1 → `out`=0 and state S0. Then in=0 for 3 edges → `out` stays 0.
- Basic detect: in = 1,1,0,1,0 on successive edges after reset → `out`=1 only in the cycle after edge 4, and 0 after edge 5.
- Overlap: in = 1,1,0,1,1,0,1,0 → `out` pulses after edges 4 and 7, and is 0 elsewhere.
- Long run of ones: in = 1,1,1,1,0,1 → S2 self-loop. `out`=1 only after edge 6.
- Near misses: in = 1,0,1,0,1,1,1,0,0,1,0,1 → `out` never asserts. Also check that after each edge the state matches the transition list.
- Reset mid-match: in = 1,1,0, then `reset`=1 with in=1 at edge 4 → `out`=0 and state S0. Next, in = 1,1,0,1 → `out`=1 after its 4th edge.
